// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// start/ready/done handshake, result held until the next conversion completes.
module bcd_seq_converter #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             overflow_q, overflow_d;

  logic [SR_W-1:0]  corr;
  logic [SR_W-1:0]  shifted;
  logic             shout;

  // Add-3 correction on every digit in parallel, from pre-correction values
  always_comb begin
    corr = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        corr[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {corr[SR_W-2:0], 1'b0};
  assign shout   = corr[SR_W-1];

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    ready_d    = ready_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = {BCD_W'(0), bin_in};
          cnt_d   = CNT_W'(0);
          ovf_d   = 1'b0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sr_d  = shifted;
        ovf_d = ovf_q | shout;
        cnt_d = cnt_q + CNT_W'(1);
        // Last iteration publishes the result and returns to IDLE
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d      = shifted[SR_W-1 -: BCD_W];
          overflow_d = ovf_q | shout;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
Multi-cycle binary-to-BCD converter. It runs the shift-and-add-3 (double dabble) algorithm one bit per clock, using a start/ready/done handshake. It replaces the fully combinational converter wherever area matters more than latency, and it is the block that sequences the conversion for display and UART report paths. The result is held stable until the next conversion completes.

Parameters:
BIN_W, 8, width of the binary input; equals the number of shift iterations.
DIGITS, 3, number of BCD digits produced; bcd_out is 4*DIGITS bits.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request a conversion; sampled only when ready=1.
bin_in  input  BIN_W  binary operand; captured on the accepting edge only.
ready  output  1  high in IDLE; a conversion may be accepted.
busy  output  1  high while iterating (CONV state); always equals ~ready.
done  output  1  one-cycle pulse; bcd_out and overflow are valid from this cycle.
bcd_out  output  4*DIGITS  packed BCD result, most significant digit at the MSBs.
overflow  output  1  the value did not fit in DIGITS digits; valid with done.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; internal shift register and iteration counter clear.
  - Outputs: ready=1, busy=0, done=0, bcd_out=0, overflow=0.
  - Reset during CONV aborts the conversion. No done pulse is issued.
- States: IDLE, CONV.
- IDLE, with start=1 at edge E:
  - Load the internal register {digits=0, bin=bin_in}.
  - Clear the counter and the internal overflow flag.
  - Go to CONV. bin_in is not sampled again.
- CONV, each edge performs exactly one iteration:
  - (a) Every 4-bit digit with value >=5 gets +3 added. All digits are corrected in parallel, from the pre-correction values.
  - (b) The whole {digits, bin} register shifts left by 1.
  - (c) If the bit shifted out of the top digit is 1, set the internal overflow flag (sticky).
  - Then increment the counter.
- Completion: the edge performing iteration BIN_W (edge E+BIN_W) does all of the following:
  - Writes the corrected, shifted digits to bcd_out.
  - Writes the overflow flag to overflow.
  - Sets done=1 and returns to IDLE.
- Latency: done is high in the cycle following edge E+BIN_W, i.e. BIN_W cycles after acceptance. Throughput is one conversion per BIN_W+1 cycles when back-to-back.
- done clears on the next edge unless another conversion completes on that edge (not possible for BIN_W>=1).
- start while busy=1 is ignored: no queuing, no effect on the current conversion.
- start in the same cycle as done=1 is accepted (state is IDLE). The new conversion begins; bcd_out keeps the just-finished result until its own completion.
- bcd_out and overflow change only at completion or reset.
- Overflow case: bcd_out holds the low DIGITS digits of the true BCD value. These are correct, because digit corrections never depend on higher digits.
- With defaults (BIN_W=8, DIGITS=3), overflow is always 0.
- Counter width is clog2(BIN_W+1). Correction adds are 4-bit with no carry between digits, because corrected digits never exceed 12.

Test Plan:
1. Reset, then start with bin_in=0; then 9, 21, 41, 108, 255 back-to-back (start held during each done cycle) -> bcd_out=0x000, 0x009, 0x021, 0x041, 0x108, 0x255; overflow=0 each time.
2. Latency: start accepted at edge E -> busy=1 for exactly 8 cycles, done=1 exactly in the cycle after edge E+8, ready=1 in that same cycle; done is a single-cycle pulse.
3. Start pulses and bin_in changes (e.g. bin_in 200 -> 7) while busy -> ignored; result equals the value captured at acceptance (200 -> 0x200), and only one done pulse occurs.
4. rst_n=0 at the 4th CONV edge of a 255 conversion -> the next cycle shows ready=1, busy=0, bcd_out=0, and no done pulse. A fresh conversion of 99 then yields 0x099.
5. Parameter instance BIN_W=8, DIGITS=2: 255 -> bcd_out=0x55, overflow=1; then 99 -> bcd_out=0x99, overflow=0 (flag cleared per conversion).
6. Hold start=1 continuously for 3 conversions with bin_in fixed at 128 -> done pulses spaced exactly 9 cycles apart, bcd_out=0x128 after each.
